// File: rtl/dot16_acc_sched.sv
// dot16_acc_sched: job sequencer for one ena-gated dot16 datapath. Streams N
// operand chunks through the datapath, follows them with a {valid,last} tag
// pipeline and folds the per-chunk results into a wide signed job sum.
// Optional feature macro: DOT16_SCHED_SAT_EN (saturating accumulation + out_ovf).
module dot16_acc_sched #(
   parameter int DATA_WIDTH  = 8,
   parameter int DOT_LATENCY = 3,
   parameter int CNT_WIDTH   = 8,
   parameter int ACC_WIDTH   = 32,
   localparam int RES_W      = 2*DATA_WIDTH+4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_WIDTH-1:0] cfg_chunks,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 dp_ena,
   input  logic [RES_W-1:0]     dp_res,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 busy
`ifdef DOT16_SCHED_SAT_EN
   ,
   output logic                 out_ovf
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [DOT_LATENCY-1:0] tag_v_q;
   logic [DOT_LATENCY-1:0] tag_l_q;

   logic                   cfg_fire, cfg_zero, chunk_fire, chunk_last;
   logic                   retire, retire_last;
   logic [ACC_WIDTH-1:0]   res_ext;
   logic [ACC_WIDTH-1:0]   sum;

   assign cfg_fire    = cfg_valid && cfg_ready;
   assign cfg_zero    = (cfg_chunks == '0);
   assign chunk_fire  = in_valid && in_ready;
   assign chunk_last  = chunk_fire && (cnt_q == '0);
   assign retire      = dp_ena && tag_v_q[DOT_LATENCY-1];
   assign retire_last = retire && tag_l_q[DOT_LATENCY-1];
   assign res_ext     = ACC_WIDTH'($signed(dp_res));

`ifdef DOT16_SCHED_SAT_EN
   logic [ACC_WIDTH:0] sum_wide;
   logic               sat_hit;
   logic               job_ovf_q;

   assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {res_ext[ACC_WIDTH-1], res_ext};
   assign sat_hit  = (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]);

   // Clamp to the signed range when the extra sign bit disagrees with the top bit
   always_comb begin
      sum = sum_wide[ACC_WIDTH-1:0];
      if (sat_hit) begin
         if (sum_wide[ACC_WIDTH]) sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         else                     sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum = acc_q + res_ext;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state: a job enters RUN, leaves RUN on its last chunk, leaves DRAIN when that chunk retires
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_fire && !cfg_zero) state_d = RUN;
         RUN:     if (chunk_last)            state_d = DRAIN;
         DRAIN:   if (retire_last)           state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs: the whole pipe freezes while an unconsumed result is held
   always_comb begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      dp_ena    = 1'b0;
      busy      = (state_q != IDLE);
      if (state_q != IDLE) dp_ena = !(out_valid && !out_ready);
      if (state_q == RUN)  in_ready = dp_ena;
      if (state_q == IDLE) cfg_ready = rst && (!out_valid || out_ready);
   end

   // Chunk counter, tag pipeline, accumulator and result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         tag_v_q   <= '0;
         tag_l_q   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef DOT16_SCHED_SAT_EN
         job_ovf_q <= 1'b0;
         out_ovf   <= 1'b0;
`endif
      end else begin
         if (dp_ena) begin
            for (int i = DOT_LATENCY-1; i > 0; i--) begin
               tag_v_q[i] <= tag_v_q[i-1];
               tag_l_q[i] <= tag_l_q[i-1];
            end
            tag_v_q[0] <= chunk_fire;
            tag_l_q[0] <= chunk_last;
         end

         if (cfg_fire) begin
            acc_q <= '0;
            if (!cfg_zero) cnt_q <= cfg_chunks - CNT_WIDTH'(1);
         end else if (chunk_fire && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end

         if (retire) acc_q <= retire_last ? '0 : sum;

         if (retire_last) begin
            out_valid <= 1'b1;
            out_data  <= sum;
         end else if (cfg_fire && cfg_zero) begin
            out_valid <= 1'b1;
            out_data  <= '0;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

`ifdef DOT16_SCHED_SAT_EN
         if (cfg_fire) begin
            job_ovf_q <= 1'b0;
            out_ovf   <= 1'b0;
         end else if (retire) begin
            job_ovf_q <= retire_last ? 1'b0 : (job_ovf_q || sat_hit);
            if (retire_last) out_ovf <= job_ovf_q || sat_hit;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dot16_acc_sched.sv
// tb_dot16_acc_sched: randomized scoreboard bench for dot16_acc_sched with a
// behavioural dot16 datapath and a plain-arithmetic job-sum reference model.
// A second instance with ACC_WIDTH=20 exercises the overflow corner.
module tb_dot16_acc_sched;

   localparam int DW  = 8;
   localparam int LAT = 3;
   localparam int CW  = 8;
   localparam int AW  = 32;
   localparam int RW  = 2*DW+4;
   localparam int SAW = 20;

   typedef struct {
      longint data;
      bit     ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          cfg_valid, cfg_ready;
   logic [CW-1:0] cfg_chunks;
   logic          in_valid, in_ready, dp_ena;
   logic [RW-1:0] dp_res;
   logic          out_valid, out_ready;
   logic [AW-1:0] out_data;
   logic          busy;
   logic          out_ovf;

   logic signed [DW-1:0] op_a [16];
   logic signed [DW-1:0] op_b [16];
   logic [RW-1:0]        dp_pipe [LAT];
   longint               dot_now;

   logic           s_cfg_valid, s_cfg_ready, s_in_valid, s_in_ready, s_dp_ena;
   logic [CW-1:0]  s_cfg_chunks;
   logic [RW-1:0]  s_dp_res;
   logic           s_out_valid, s_out_ready, s_busy, s_out_ovf;
   logic [SAW-1:0] s_out_data;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ready_mode = 1;

   dot16_acc_sched #(.DATA_WIDTH(DW), .DOT_LATENCY(LAT), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chunks(cfg_chunks),
      .in_valid(in_valid), .in_ready(in_ready), .dp_ena(dp_ena), .dp_res(dp_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef DOT16_SCHED_SAT_EN
      , .out_ovf(out_ovf)
`endif
   );

   dot16_acc_sched #(.DATA_WIDTH(DW), .DOT_LATENCY(LAT), .CNT_WIDTH(CW), .ACC_WIDTH(SAW)) dut_s (
      .clk(clk), .rst(rst),
      .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_chunks(s_cfg_chunks),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .dp_ena(s_dp_ena), .dp_res(s_dp_res),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
`ifdef DOT16_SCHED_SAT_EN
      , .out_ovf(s_out_ovf)
`endif
   );

`ifndef DOT16_SCHED_SAT_EN
   assign out_ovf   = 1'b0;
   assign s_out_ovf = 1'b0;
`endif

   // Behavioural datapath: sum of 16 signed products of whatever is on a/b
   always_comb begin
      dot_now = 0;
      for (int i = 0; i < 16; i++) dot_now += longint'(op_a[i]) * longint'(op_b[i]);
   end

   // Datapath pipeline, advancing only while enabled
   always @(posedge clk) begin
      if (dp_ena) begin
         dp_pipe[0] <= RW'(dot_now);
         for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
      end
   end
   assign dp_res = dp_pipe[LAT-1];

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference rule for one retire: signed add, then wrap or clamp to w bits
   function automatic void fold(input longint acc, input longint res, input int w,
                                output longint s, output bit sat);
      longint maxv = (longint'(1) <<< (w-1)) - 1;
      longint minv = -(longint'(1) <<< (w-1));
      s   = acc + res;
      sat = 1'b0;
`ifdef DOT16_SCHED_SAT_EN
      if (s > maxv)      begin s = maxv; sat = 1'b1; end
      else if (s < minv) begin s = minv; sat = 1'b1; end
`else
      if (s > maxv)      s -= (longint'(1) <<< w);
      else if (s < minv) s += (longint'(1) <<< w);
`endif
   endfunction

   task automatic set_operands(input bit fixed, input logic signed [DW-1:0] fa,
                               input logic signed [DW-1:0] fb);
      for (int i = 0; i < 16; i++) begin
         op_a[i] = fixed ? fa : DW'($urandom);
         op_b[i] = fixed ? fb : DW'($urandom);
      end
   endtask

   // One job: cfg handshake then n chunks; expected sum pushed before the DUT can present it.
   // Called and returns at posedge+1. gap<0 means a random 0..2 bubble cycles between chunks.
   task automatic apply_stimulus(input int n, input int gap, input bit push_exp, input bit fixed,
                                 input logic signed [DW-1:0] fa, input logic signed [DW-1:0] fb,
                                 output longint exp_sum);
      longint acc = 0;
      longint s;
      longint d;
      bit     ovf = 1'b0;
      bit     sat;
      bit     ok;
      int     guard;
      exp_t   e;
      cfg_valid  = 1'b1;
      cfg_chunks = CW'(n);
      guard = 0;
      ok    = 1'b0;
      while (!ok && guard < 300) begin
         @(negedge clk);
         ok = cfg_ready;
         if (!ok) begin @(posedge clk); #1; end
         guard++;
      end
      if (!ok) begin
         check_output("cfg_accept_timeout", 0, 1);
         cfg_valid = 1'b0;
         exp_sum   = 0;
         return;
      end
      if (push_exp && n == 0) begin
         e.data = 0; e.ovf = 1'b0;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      for (int c = 0; c < n; c++) begin
         int nb = (gap < 0) ? $urandom_range(2) : gap;
         if (c > 0) begin
            for (int k = 0; k < nb; k++) begin
               in_valid = 1'b0;
               set_operands(1'b0, '0, '0);
               @(posedge clk); #1;
            end
         end
         set_operands(fixed, fa, fb);
         in_valid = 1'b1;
         d = 0;
         for (int i = 0; i < 16; i++) d += longint'(op_a[i]) * longint'(op_b[i]);
         guard = 0;
         ok    = 1'b0;
         while (!ok && guard < 300) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) begin @(posedge clk); #1; end
            guard++;
         end
         if (!ok) begin
            check_output("chunk_accept_timeout", 0, 1);
            in_valid = 1'b0;
            exp_sum  = acc;
            return;
         end
         fold(acc, d, AW, s, sat);
         acc = s;
         ovf = ovf | sat;
         if (push_exp && c == n-1) begin
            e.data = acc; e.ovf = ovf;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      exp_sum = acc;
   endtask

   // Called right after the last chunk handshake with out_ready high and nothing pending
   task automatic check_latency(input string name);
      for (int k = 1; k <= LAT+1; k++) begin
         @(negedge clk);
         if (k < LAT+1) check_output({name, "_no_early_valid"}, longint'(out_valid), 0);
         if (k == LAT)  check_output({name, "_busy_before"}, longint'(busy), 1);
         if (k == LAT+1) begin
            check_output({name, "_valid_rise"}, longint'(out_valid), 1);
            check_output({name, "_busy_drop"}, longint'(busy), 0);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input string name);
      int guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check_output({name, "_drained"}, longint'(exp_q.size()), 0);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: every output handshake pops and compares one expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_result", longint'($signed(out_data)), -1);
            end else begin
               e = exp_q.pop_front();
               check_output("out_data", longint'($signed(out_data)), e.data);
`ifdef DOT16_SCHED_SAT_EN
               check_output("out_ovf", longint'(out_ovf), longint'(e.ovf));
`endif
            end
         end
      end
   end

   // Result-side backpressure driver
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint sum, held, acc_s, s_tmp;
      bit     sat, ovf_s;
      int     cnt, guard;
      rst = 1'b0; cfg_valid = 1'b0; cfg_chunks = '0; in_valid = 1'b0;
      set_operands(1'b1, '0, '0);
      s_cfg_valid = 1'b0; s_cfg_chunks = '0; s_in_valid = 1'b0;
      s_dp_res = RW'(262144); s_out_ready = 1'b1;

      #12;
      check_output("rst_out_valid", longint'(out_valid), 0);
      check_output("rst_out_data", longint'(out_data), 0);
      check_output("rst_cfg_ready", longint'(cfg_ready), 0);
      check_output("rst_dp_ena", longint'(dp_ena), 0);
      check_output("rst_in_ready", longint'(in_ready), 0);
      check_output("rst_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      $display("[TB] 4 chunks of a=1 b=2");
      apply_stimulus(4, 0, 1'b1, 1'b1, 8'sd1, 8'sd2, sum);
      check_latency("t1");
      wait_drain("t1");

      $display("[TB] 3 chunks of a=-128 b=127");
      apply_stimulus(3, 0, 1'b1, 1'b1, -8'sd128, 8'sd127, sum);
      wait_drain("t2");

      $display("[TB] 2 chunks with bubbles");
      apply_stimulus(2, 1, 1'b1, 1'b0, '0, '0, sum);
      check_latency("t3");
      wait_drain("t3");

      $display("[TB] held result blocks the next job");
      ready_mode = 0;
      apply_stimulus(2, 0, 1'b1, 1'b0, '0, '0, held);
      for (int k = 0; k < LAT+1; k++) @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_chunks = CW'(2);
      for (int k = 0; k < 3; k++) begin
         check_output("t4_valid_held", longint'(out_valid), 1);
         check_output("t4_cfg_blocked", longint'(cfg_ready), 0);
         check_output("t4_dp_ena", longint'(dp_ena), 0);
         check_output("t4_in_ready", longint'(in_ready), 0);
         check_output("t4_data_held", longint'($signed(out_data)), held);
         @(negedge clk);
      end
      @(posedge clk); #1;
      ready_mode = 1;
      apply_stimulus(2, 0, 1'b1, 1'b0, '0, '0, sum);
      wait_drain("t4");

      $display("[TB] zero-chunk job");
      apply_stimulus(0, 0, 1'b1, 1'b0, '0, '0, sum);
      check_output("t5_zero_valid", longint'(out_valid), 1);
      check_output("t5_zero_in_ready", longint'(in_ready), 0);
      wait_drain("t5");

      $display("[TB] reset during drain");
      apply_stimulus(3, 0, 1'b0, 1'b0, '0, '0, sum);
      check_output("t5_in_drain", longint'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check_output("t5_rst_out_valid", longint'(out_valid), 0);
      check_output("t5_rst_busy", longint'(busy), 0);
      check_output("t5_rst_dp_ena", longint'(dp_ena), 0);
      check_output("t5_rst_cfg_ready", longint'(cfg_ready), 0);
      check_output("t5_rst_out_data", longint'(out_data), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check_output("t5_no_result_after_reset", longint'(cnt), 0);
      @(posedge clk); #1;

      $display("[TB] randomized jobs with random backpressure");
      ready_mode = 2;
      for (int j = 0; j < 30; j++) apply_stimulus($urandom_range(6), -1, 1'b1, 1'b0, '0, '0, sum);
      apply_stimulus((1 << CW) - 1, 0, 1'b1, 1'b0, '0, '0, sum);
      ready_mode = 1;
      wait_drain("random");

      $display("[TB] narrow accumulator overflow");
      s_cfg_valid  = 1'b1;
      s_cfg_chunks = CW'(3);
      @(posedge clk); #1;
      s_cfg_valid = 1'b0;
      s_in_valid  = 1'b1;
      guard = 0;
      while (!s_out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      s_in_valid = 1'b0;
      acc_s = 0;
      ovf_s = 1'b0;
      for (int c = 0; c < 3; c++) begin
         fold(acc_s, 262144, SAW, s_tmp, sat);
         acc_s = s_tmp;
         ovf_s = ovf_s | sat;
      end
      check_output("t6_valid", longint'(s_out_valid), 1);
      check_output("t6_out_data", longint'($signed(s_out_data)), acc_s);
`ifdef DOT16_SCHED_SAT_EN
      check_output("t6_out_ovf", longint'(s_out_ovf), longint'(ovf_s));
`endif
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
